// File: rtl/reset_seq.sv
// reset_seq: chip-root reset sequencer. Holds N_OUT active-low domain resets
// for HOLD_CYCLES after reset, then releases them one at a time in ascending
// index order, GAP_CYCLES apart. A level request on i_req, seen through a
// SYNC_STAGES-deep synchroniser, re-asserts every output and restarts the
// sequence from the beginning.
module reset_seq #(
  parameter int unsigned N_OUT       = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned HOLD_CYCLES = 16,
  parameter int unsigned GAP_CYCLES  = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_req,
  output logic [N_OUT-1:0] o_rst_n,
  output logic             o_done
);

  localparam int unsigned MAX_CNT = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int unsigned CNT_W   = $clog2(MAX_CNT + 1);
  localparam int unsigned IDX_W   = $clog2(N_OUT + 1);

  localparam logic [CNT_W-1:0] HOLD_CNT = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] GAP_CNT  = CNT_W'(GAP_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_OUT);

  typedef enum logic {
    S_HOLD = 1'b0,
    S_REL  = 1'b1
  } state_e;

  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [N_OUT-1:0]       rst_n_q, rst_n_d;
  logic                   done_q, done_d;
  logic [SYNC_STAGES-1:0] sync_q, sync_d;

  logic                   req_s;
  logic [CNT_W-1:0]       cnt_inc;

  assign req_s   = sync_q[SYNC_STAGES-1];
  assign cnt_inc = cnt_q + CNT_W'(1);

  // Request synchroniser: keeps shifting even while a request is being served.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], i_req};
  end

  // Sequencer next state: request clears everything, otherwise count and release.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    rst_n_d = rst_n_q;

    if (req_s) begin
      state_d = S_HOLD;
      cnt_d   = '0;
      idx_d   = '0;
      rst_n_d = '0;
    end else begin
      unique case (state_q)
        S_HOLD: begin
          if (cnt_inc == HOLD_CNT) begin
            rst_n_d[0] = 1'b1;
            idx_d      = IDX_W'(1);
            cnt_d      = '0;
            state_d    = S_REL;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        S_REL: begin
          if (idx_q < LAST_IDX) begin
            if (cnt_inc == GAP_CNT) begin
              for (int unsigned i = 0; i < N_OUT; i++) begin
                if (idx_q == IDX_W'(i)) begin
                  rst_n_d[i] = 1'b1;
                end
              end
              idx_d = idx_q + IDX_W'(1);
              cnt_d = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = S_HOLD;
          cnt_d   = '0;
          idx_d   = '0;
          rst_n_d = '0;
        end
      endcase
    end

    // Done tracks the outputs being registered this edge, so it rises with the last release.
    done_d = &rst_n_d;
  end

  // State registers with synchronous master reset.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q  <= '0;
      state_q <= S_HOLD;
      cnt_q   <= '0;
      idx_q   <= '0;
      rst_n_q <= '0;
      done_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      rst_n_q <= rst_n_d;
      done_q  <= done_d;
    end
  end

  assign o_rst_n = rst_n_q;
  assign o_done  = done_q;

endmodule
